instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Instruction-fetch initiator that drives byte addresses to the instruction ROM and collects the returned words. It keeps the program counter and buffers fetched instructions in a small queue. It hands instructions to decode over a valid/ready handshake. Branch and jump redirects restart fetch at a new PC and flush everything already in flight.

Parameters:
DATA_WIDTH, 32, instruction and address width in bits.
RESET_PC, 32'h0040_0000, PC loaded on reset (text-segment base that the ROM maps to word 0).
QUEUE_DEPTH, 2, number of fetch-queue entries (power of two, >=2).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, synchronous, active-low.
imem_addr  output  DATA_WIDTH  byte address to instruction ROM.
imem_rd  input  DATA_WIDTH  ROM read data, combinational from imem_addr in the same cycle.
redirect_valid  input  1  restart fetch at redirect_pc.
redirect_pc  input  DATA_WIDTH  new fetch byte address.
instr_valid  output  1  queue head holds a valid instruction.
instr_ready  input  1  decode accepts the head this cycle.
instr_data  output  DATA_WIDTH  instruction word at queue head.
instr_pc  output  DATA_WIDTH  byte PC of instr_data.
misalign  output  1  sticky misaligned-redirect flag (present only with FETCH_MISALIGN_CHK_EN).

Behaviour:
- Reset (rst_n low at clk edge):
  - fetch_pc <= RESET_PC; queue count <= 0.
  - instr_valid=0, instr_data=0, instr_pc=0, misalign=0.
  - Reset asserted mid-operation discards all queue contents and any pending redirect.
- imem_addr = fetch_pc, driven directly from the register; no combinational path from redirect_pc.
- pop = instr_valid & instr_ready.
- push = !redirect_valid & (count < QUEUE_DEPTH | pop).
  - A push writes {fetch_pc, imem_rd} at the queue tail; fetch_pc <= fetch_pc + 4.
- Addition is modulo 2^DATA_WIDTH: 32'hFFFF_FFFC wraps to 0.
- A simultaneous push and pop on a full queue is legal; count is unchanged.
- Queue full with no pop: no push; fetch_pc and imem_addr hold.
- Queue empty: instr_valid=0. instr_data and instr_pc hold their last value and are don't-care to the consumer.
- Redirect has highest priority:
  - count <= 0; fetch_pc <= redirect_pc; no push that cycle.
  - A pop in the same cycle is discarded.
  - instr_valid=0 in the cycle after the redirect.
  - Target instruction enters the queue at the next edge; instr_valid=1 two cycles after the redirect edge (latency 2).
- Back-to-back redirects: the last one wins; nothing from an intermediate target is delivered.
- Latency from reset release: first push at the first edge with rst_n=1; instr_valid=1 the cycle after.
- Steady-state throughput: 1 instruction/cycle while instr_ready=1.
- Queue order is strict FIFO. Read and write pointers wrap modulo QUEUE_DEPTH.
- Registers: fetch_pc, queue storage, wr_ptr, rd_ptr, count (clog2(QUEUE_DEPTH)+1 bits).

Optional Feature:
FETCH_MISALIGN_CHK_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 still flushes the queue, but fetch_pc holds its old value.
  - misalign <= 1 and stays set until reset.
  - While misalign=1, push is suppressed and instr_valid stays 0.
- Undefined:
  - misalign port absent.
  - redirect_pc[1:0] forced to 0 when loaded into fetch_pc.

Decomposition:
- Package fetch_pkg:
  - DATA_WIDTH default.
  - RESET_PC.
  - PC_INCR=4.
  - Packed typedef fetch_entry_t {pc, instr}.
- Sub-module fetch_queue:
  - Parameterised FIFO of fetch_entry_t with push/pop/flush and full/empty.
  - The top level holds fetch_pc and the push/redirect control.

Test Plan:
- Reset sequence: rst_n low 3 cycles, then high, instr_ready=1, ROM contents 0x1000_0001+i -> imem_addr 0x0040_0000, 0x0040_0004, 0x0040_0008; instr_valid rises 1 cycle after release; instr_pc/instr_data = 0x0040_0000/0x1000_0001 followed by +4/+1 each cycle.
- Back-pressure: instr_ready=0 for 5 cycles -> queue fills to 2; imem_addr frozen at 0x0040_0008; on instr_ready=1 delivery resumes with no loss or duplication.
- Redirect: pulse redirect_valid with redirect_pc=0x0040_0100 while queue full -> instr_valid=0 next cycle; 2 cycles later instr_pc=0x0040_0100; stale entries never appear.
- Simultaneous redirect and pop: instr_ready=1 during redirect to 0x0040_0020 -> popped entry not counted; next delivered PC is 0x0040_0020.
- Wrap-around: redirect to 0xFFFF_FFF8 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x0040_0102 -> misalign=1 sticky, instr_valid stays 0 until reset. Without the macro, the same redirect fetches 0x0040_0100.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared defaults, fetch-queue entry type and helpers for the instruction fetch unit.
// The optional misaligned-redirect check is enabled with FETCH_MISALIGN_CHK_EN.
package fetch_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam logic [DEF_DATA_WIDTH-1:0] DEF_RESET_PC = 32'h0040_0000;
    localparam int unsigned PC_INCR = 4;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] pc;
        logic [DEF_DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM, redirect and decode-handshake signals of the fetch unit; master = fetch unit side.
// The misalign flag exists only when FETCH_MISALIGN_CHK_EN is defined.
interface instr_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = fetch_pkg::DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_rd;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [DATA_WIDTH-1:0] instr_pc;

`ifdef FETCH_MISALIGN_CHK_EN
    logic                  misalign;

    modport master (
        output imem_addr,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc,
        output misalign
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc,
        input  misalign
    );
`else
    modport master (
        output imem_addr,
        input  imem_rd,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rd,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
`endif

endinterface

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with push/pop/flush; flush wins over push and pop.
// The head output holds its last shown value while the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned Depth   = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   full_o,
    output logic   empty_o,
    output entry_t head_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = PtrW + 1;

    entry_t          mem_q [Depth];
    entry_t          last_q;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    assign head_o = empty_o ? last_q : mem_q[rd_ptr_q];

    // Pointers wrap naturally because Depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= head_o;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch initiator: owns the PC, fills the fetch queue and handles redirects.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets with a sticky flag.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = DEF_RESET_PC,
    parameter int unsigned           QUEUE_DEPTH = 2
) (
    input logic                clk,
    input logic                rst_n,
    instr_fetch_unit_if.master fetch_if
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                  flush;
    logic                  push;
    logic                  pop;
    logic                  fetch_en;
    logic                  q_full;
    logic                  q_empty;
    entry_t                push_entry;
    entry_t                head;

    assign flush = fetch_if.redirect_valid;

`ifdef FETCH_MISALIGN_CHK_EN
    logic misalign_q, misalign_d;
    logic bad_target;

    assign bad_target = flush && !is_word_aligned(fetch_if.redirect_pc[1:0]);
    assign fetch_en   = !misalign_q;

    always_comb begin
        misalign_d = misalign_q;
        if (bad_target) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign fetch_if.misalign = misalign_q;
`else
    assign fetch_en = 1'b1;
`endif

    assign fetch_if.imem_addr   = fetch_pc_q;
    assign fetch_if.instr_valid = !q_empty && fetch_en;
    assign fetch_if.instr_data  = head.instr;
    assign fetch_if.instr_pc    = head.pc;

    // A pop frees a slot in the same cycle, so a full queue still streams.
    assign pop  = fetch_if.instr_valid && fetch_if.instr_ready;
    assign push = !flush && fetch_en && (!q_full || pop);

    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = fetch_if.imem_rd;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (flush) begin
`ifdef FETCH_MISALIGN_CHK_EN
            if (!bad_target) begin
                fetch_pc_d = fetch_if.redirect_pc;
            end
`else
            fetch_pc_d = {fetch_if.redirect_pc[DATA_WIDTH-1:2], 2'b00};
`endif
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCR);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .Depth   (QUEUE_DEPTH)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .head_o      (head)
    );

endmodule
